align_accumulate: RTL and testbench
===================================

Name: align_accumulate

Overview:
- Front-end accumulation stage of the SD4 MAC datapath: receives a stream of unpacked floating-point terms (sign, 11-bit mantissa with hidden bit, signed 6-bit exponent) over a valid/ready handshake.
- Buffers one group, finds the group's maximum exponent, then aligns each term to it and accumulates a 20-bit two's-complement sum.
- Produces exactly the signed_sum / exp_max pair consumed by the normalization stage: bit 10 of signed_sum carries weight 2^exp_max; bit 19 is the sign.

Parameters:
- N_TERMS, 4, maximum terms per group (legal range 1..256; the 20-bit sum cannot overflow in that range).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  term present.
- in_ready  output  1  block can accept a term this cycle.
- in_sign  input  1  term sign (1 = negative).
- in_mant  input  11  term magnitude with hidden bit at bit 10; 0 means a zero term.
- in_exp  input  6  signed term exponent, range -32..31.
- in_last  input  1  term closes the current group.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- signed_sum  output  20  signed aligned sum.
- exp_max  output  6  signed group exponent.

Behaviour:
- Reset, synchronous and active-high: state goes to COLLECT, count = 0, accumulator = 0, running max cleared, out_valid = 0, signed_sum = 0, exp_max = 0. in_ready = 0 while rst is high and 1 in the first cycle after. Reset mid-group or mid-ALIGN discards all buffered terms.
- A term is accepted only on an edge where in_valid && in_ready.
- COLLECT state:
  - in_ready = 1.
  - Each accepted term is stored at buffer[count]; count increments.
  - The running max exponent updates only for terms with in_mant != 0.
  - Move to ALIGN on the edge that accepts a term with in_last = 1, or the edge that accepts the N_TERMS-th term. in_last is ignored on that N_TERMS-th term.
- ALIGN state:
  - in_ready = 0.
  - One buffered term per cycle, in arrival order.
  - Shift distance d = exp_max - exp_i, computed unsigned over 7 bits, range 0..63.
  - Aligned magnitude = mant >> d, truncated. Any d >= 11 yields 0.
  - The magnitude is negated in two's complement when sign = 1, then added to the 20-bit accumulator.
  - If every term in the group is zero, exp_max = 0 and the sum is 0.
- OUTPUT state:
  - The edge that adds the last buffered term registers signed_sum and exp_max and sets out_valid = 1. For a k-term group, out_valid is high exactly k edges after the edge that accepted the last term.
  - signed_sum and exp_max are held stable while out_valid && !out_ready.
  - On an edge with out_valid && out_ready: out_valid goes to 0, accumulator, count and max clear, and the state returns to COLLECT. in_ready rises on the following cycle; groups never overlap.
- Outputs are registered; there is no combinational path from in_* to out_*, nor from out_ready to in_ready.

Decomposition:
- Shared package holds:
  - constants MANT_W = 11, EXP_W = 6, SUM_W = 20, HIDDEN_POS = 10;
  - the state enum COLLECT / ALIGN / OUTPUT.
- The normalization stage imports the same constants.
- One combinational sub-module, sd4_align_shift: inputs sign, mant, d; output is the 20-bit two's-complement aligned term, covering the shift, the d >= 11 zeroing and the conditional negate.

Test Plan:
- Single term: +0x400 exp 3, in_last → out_valid 1 edge later; signed_sum 0x00400, exp_max 3.
- Alignment: +0x400 exp 2, then +0x400 exp 0 with in_last → exp_max 2, signed_sum 0x00500.
- Signs:
  - +0x600 exp 1 and -0x400 exp 1 → 0x00200.
  - A lone -0x400 exp 0 → 0xFFC00.
- Extreme shift and zero handling:
  - +0x7FF exp 31, then +0x7FF exp -32 (d = 63) → signed_sum 0x007FF, exp_max 31.
  - An all-zero-mantissa group → signed_sum 0, exp_max 0.
- Count limit and backpressure, N_TERMS = 4:
  - Four +0x7FF exp 0 with no in_last → in_ready low after the 4th term; signed_sum 0x01FFC.
  - Hold out_ready low for 3 cycles → outputs stable throughout, in_ready remains 0.
- Reset during ALIGN of a 3-term group → out_valid 0 and in_ready 1 the cycle after reset. A new single term +0x400 exp 0 then gives 0x00400 with no residue from the aborted group.

Source files
------------

// File: rtl/align_accumulate_pkg.sv
// rtl/align_accumulate_pkg.sv - shared widths, state encoding and term record for the SD4 align/accumulate stage
package align_accumulate_pkg;

  localparam int MANT_W     = 11;
  localparam int EXP_W      = 6;
  localparam int SUM_W      = 20;
  localparam int HIDDEN_POS = 10;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ALIGN   = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // One buffered term; exp is two's complement
  typedef struct packed {
    logic              sign;
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
  } term_t;

endpackage

// File: rtl/align_accumulate_if.sv
// rtl/align_accumulate_if.sv - term input and sum output handshake bundle
interface align_accumulate_if;
  import align_accumulate_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  signed_sum;
  logic [EXP_W-1:0]  exp_max;

  modport slave (
    input  in_valid, in_sign, in_mant, in_exp, in_last, out_ready,
    output in_ready, out_valid, signed_sum, exp_max
  );

  modport master (
    output in_valid, in_sign, in_mant, in_exp, in_last, out_ready,
    input  in_ready, out_valid, signed_sum, exp_max
  );

endinterface

// File: rtl/align_accumulate_shift.sv
// rtl/align_accumulate_shift.sv - aligns one term to the group exponent and applies its sign
module sd4_align_shift
  import align_accumulate_pkg::*;
(
  input  logic              i_sign,
  input  logic [MANT_W-1:0] i_mant,
  input  logic [EXP_W:0]    i_d,
  output logic [SUM_W-1:0]  o_term
);

  // Any shift of MANT_W or more pushes the hidden bit out entirely
  localparam logic [EXP_W:0] D_ZERO = MANT_W;

  logic [MANT_W-1:0] w_mag;
  logic [SUM_W-1:0]  w_ext;

  assign w_mag  = (i_d >= D_ZERO) ? '0 : (i_mant >> i_d);
  assign w_ext  = {{(SUM_W-MANT_W){1'b0}}, w_mag};
  assign o_term = i_sign ? (-w_ext) : w_ext;

endmodule

// File: rtl/align_accumulate.sv
// rtl/align_accumulate.sv - buffers a term group, finds its max exponent, then aligns and sums the terms
module align_accumulate
  import align_accumulate_pkg::*;
#(
  parameter int N_TERMS = 4
) (
  input  logic               clk,
  input  logic               rst,
  align_accumulate_if.slave  bus
);

  localparam int IDX_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  term_t             r_buf [N_TERMS];
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_idx;
  logic [EXP_W-1:0]  r_max;
  logic              r_any_nz;
  logic [SUM_W-1:0]  r_acc;
  logic [SUM_W-1:0]  r_sum;
  logic [EXP_W-1:0]  r_exp_out;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_close;
  logic              w_align_last;
  term_t             w_cur;
  logic [EXP_W:0]    w_d;
  logic [SUM_W-1:0]  w_term;

  // in_ready depends only on state and reset, never on out_ready
  assign bus.in_ready   = (r_state == COLLECT) && !rst;
  assign w_accept       = bus.in_valid && bus.in_ready;
  // The N_TERMS-th term closes the group whatever its in_last says
  assign w_close        = w_accept && (bus.in_last || (r_count == LAST_CNT));
  assign w_cur          = r_buf[r_idx[IDX_W-1:0]];
  assign w_align_last   = (r_state == ALIGN) && (r_idx == (r_count - ONE));
  // Sign-extend both exponents to 7 bits so the difference never wraps for nonzero terms
  assign w_d            = {r_max[EXP_W-1], r_max} - {w_cur.exp[EXP_W-1], w_cur.exp};

  sd4_align_shift u_shift (
    .i_sign (w_cur.sign),
    .i_mant (w_cur.mant),
    .i_d    (w_d),
    .o_term (w_term)
  );

  assign bus.out_valid  = r_out_valid;
  assign bus.signed_sum = r_sum;
  assign bus.exp_max    = r_exp_out;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: collect until closed, walk the buffer, wait for the result handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if (w_close)       w_state_nxt = ALIGN;
      ALIGN:   if (w_align_last)  w_state_nxt = OUTPUT;
      OUTPUT:  if (bus.out_ready) w_state_nxt = COLLECT;
      default:                    w_state_nxt = COLLECT;
    endcase
  end

  // Term buffer; contents only matter below r_count so it needs no reset
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_count[IDX_W-1:0]] <= '{sign: bus.in_sign, mant: bus.in_mant, exp: bus.in_exp};
  end

  // Running max, accumulator and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_idx       <= '0;
      r_max       <= '0;
      r_any_nz    <= 1'b0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_exp_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_count <= r_count + ONE;
            // Zero terms carry no magnitude, so they never set the group exponent
            if ((bus.in_mant != '0) && (!r_any_nz || ($signed(bus.in_exp) > $signed(r_max)))) begin
              r_max    <= bus.in_exp;
              r_any_nz <= 1'b1;
            end
          end
        end
        ALIGN: begin
          r_acc <= r_acc + w_term;
          r_idx <= r_idx + ONE;
          if (w_align_last) begin
            r_sum       <= r_acc + w_term;
            r_exp_out   <= r_any_nz ? r_max : '0;
            r_out_valid <= 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_max       <= '0;
            r_any_nz    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_align_accumulate.sv
// tb/tb_align_accumulate.sv - self-checking bench for align_accumulate
module tb_align_accumulate;
  import align_accumulate_pkg::*;

  logic clk = 1'b0;
  logic rst;

  align_accumulate_if bus ();

  align_accumulate #(.N_TERMS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] sum;
    logic [5:0]  ex;
    int          lat;
  } exp_t;

  exp_t sb[$];

  // Element [0] of each packed array is the first term sent
  typedef struct {
    int                n;
    logic              last;
    logic [3:0]        sgn;
    logic [3:0][10:0]  m;
    logic [3:0][5:0]   e;
    logic [19:0]       sum;
    logic [5:0]        ex;
    int                hold;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic drive_group(input int n, input logic last, input logic [3:0] sgn,
                             input logic [3:0][10:0] m, input logic [3:0][5:0] e);
    for (int i = 0; i < n; i++) begin
      int w;
      bus.in_valid = 1'b1;
      bus.in_sign  = sgn[i];
      bus.in_mant  = m[i];
      bus.in_exp   = e[i];
      bus.in_last  = last && (i == n - 1);
      w = 0;
      while (!bus.in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!bus.in_ready) check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(input int hold);
    exp_t x;
    int   lat;
    check("in_ready_align", {31'd0, bus.in_ready}, 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("latency", lat, x.lat);
      check("signed_sum", {12'd0, bus.signed_sum}, {12'd0, x.sum});
      check("exp_max", {26'd0, bus.exp_max}, {26'd0, x.ex});
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_sum", {12'd0, bus.signed_sum}, {12'd0, x.sum});
        check("hold_exp", {26'd0, bus.exp_max}, {26'd0, x.ex});
        check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_cleared", {31'd0, bus.out_valid}, 32'd0);
    check("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Reference: max exponent over nonzero terms, truncating integer shifts, signed integer sum
  function automatic void model(input int n, input logic [3:0] sgn, input logic [3:0][10:0] m,
                                input logic [3:0][5:0] e, output logic [19:0] sum, output logic [5:0] ex);
    int mx;
    bit any;
    int acc;
    any = 0;
    mx  = 0;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      int ei;
      ei = $signed(e[i]);
      if (m[i] != 0) begin
        if (!any || ei > mx) mx = ei;
        any = 1;
      end
    end
    for (int i = 0; i < n; i++) begin
      int d;
      int mag;
      int ei;
      ei  = $signed(e[i]);
      d   = mx - ei;
      mag = (m[i] == 0 || d >= 11) ? 0 : (int'(m[i]) >> d);
      acc = sgn[i] ? acc - mag : acc + mag;
    end
    sum = acc[19:0];
    ex  = any ? mx[5:0] : 6'd0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0]       rs;
    logic [3:0][10:0] rm;
    logic [3:0][5:0]  re;
    logic [19:0]      ms;
    logic [5:0]       mex;
    int               rn;
    logic             rl;

    vecs[0] = '{n: 1, last: 1'b1, sgn: 4'b0000, m: {11'h0, 11'h0, 11'h0, 11'h400},
                e: {6'd0, 6'd0, 6'd0, 6'd3}, sum: 20'h00400, ex: 6'd3, hold: 0};
    vecs[1] = '{n: 2, last: 1'b1, sgn: 4'b0000, m: {11'h0, 11'h0, 11'h400, 11'h400},
                e: {6'd0, 6'd0, 6'd0, 6'd2}, sum: 20'h00500, ex: 6'd2, hold: 0};
    vecs[2] = '{n: 2, last: 1'b1, sgn: 4'b0010, m: {11'h0, 11'h0, 11'h400, 11'h600},
                e: {6'd0, 6'd0, 6'd1, 6'd1}, sum: 20'h00200, ex: 6'd1, hold: 0};
    vecs[3] = '{n: 1, last: 1'b1, sgn: 4'b0001, m: {11'h0, 11'h0, 11'h0, 11'h400},
                e: {6'd0, 6'd0, 6'd0, 6'd0}, sum: 20'hFFC00, ex: 6'd0, hold: 0};
    vecs[4] = '{n: 2, last: 1'b1, sgn: 4'b0000, m: {11'h0, 11'h0, 11'h7FF, 11'h7FF},
                e: {6'd0, 6'd0, 6'h20, 6'h1F}, sum: 20'h007FF, ex: 6'h1F, hold: 0};
    vecs[5] = '{n: 3, last: 1'b1, sgn: 4'b0000, m: {11'h0, 11'h0, 11'h0, 11'h0},
                e: {6'd0, 6'd7, 6'h3D, 6'd5}, sum: 20'h00000, ex: 6'd0, hold: 0};
    vecs[6] = '{n: 4, last: 1'b0, sgn: 4'b0000, m: {11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF},
                e: {6'd0, 6'd0, 6'd0, 6'd0}, sum: 20'h01FFC, ex: 6'd0, hold: 3};
    vecs[7] = '{n: 2, last: 1'b1, sgn: 4'b0000, m: {11'h0, 11'h0, 11'h400, 11'h000},
                e: {6'd0, 6'd0, 6'd1, 6'd20}, sum: 20'h00400, ex: 6'd1, hold: 0};
    vecs[8] = '{n: 3, last: 1'b1, sgn: 4'b0000, m: {11'h0, 11'h7FF, 11'h7FF, 11'h400},
                e: {6'd0, 6'd0, 6'd1, 6'd11}, sum: 20'h00401, ex: 6'd11, hold: 0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum", {12'd0, bus.signed_sum}, 32'd0);
    check("rst_exp", {26'd0, bus.exp_max}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      drive_group(vecs[i].n, vecs[i].last, vecs[i].sgn, vecs[i].m, vecs[i].e);
      sb.push_back('{sum: vecs[i].sum, ex: vecs[i].ex, lat: vecs[i].n});
      get_result(vecs[i].hold);
    end

    for (int g = 0; g < 8; g++) begin
      rn = $urandom_range(1, 4);
      rl = (rn < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        rs[i] = 1'($urandom_range(0, 1));
        rm[i] = ($urandom_range(0, 3) == 0) ? 11'h0 : 11'($urandom_range(11'h400, 11'h7FF));
        re[i] = 6'($urandom_range(0, 63));
      end
      model(rn, rs, rm, re, ms, mex);
      drive_group(rn, rl, rs, rm, re);
      sb.push_back('{sum: ms, ex: mex, lat: rn});
      get_result(0);
    end

    drive_group(3, 1'b1, 4'b0000, {11'h0, 11'h400, 11'h400, 11'h400}, {6'd0, 6'd0, 6'd0, 6'd0});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("abort_no_result", {31'd0, bus.out_valid}, 32'd0);
    drive_group(1, 1'b1, 4'b0000, {11'h0, 11'h0, 11'h0, 11'h400}, {6'd0, 6'd0, 6'd0, 6'd0});
    sb.push_back('{sum: 20'h00400, ex: 6'd0, lat: 1});
    get_result(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
